axi_lite_arbiter: RTL and testbench

- Two-master, one-slave AXI4-lite arbiter placed between the fetch unit (IFU, read-only) and the load/store unit (LSU, read and write) on one side, and the single memory/SRAM slave on the other.
- A registered FSM grants the slave to exactly one transaction at a time and routes that master's channels through combinationally.
- The grant is released only after the transaction's response handshake completes.

---
 rtl/npc_axi_pkg.sv | 15 +
 rtl/axi_lite_arbiter_if.sv | 35 +++
 rtl/Reg.sv | 21 ++
 rtl/arb_pick.sv | 40 ++++
 rtl/axi_lite_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_lite_arbiter.sv | 165 ++++++++++++++++
 6 files changed

// File: rtl/npc_axi_pkg.sv
// Shared AXI-lite definitions for the NPC memory path: arbiter state encoding and response codes.
package npc_axi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-lite bundle (all five channels). master = manager side, slave = subordinate side.
interface axi_lite_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/Reg.sv
// Generic register primitive with asynchronous active-high reset and write enable.
module Reg #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dout <= RESET_VAL;
        end else if (i_wen) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/arb_pick.sv
// Request-to-grant selector. ARB_RR_EN selects round-robin between IFU and LSU,
// otherwise LSU has fixed priority. An LSU read always beats an LSU write.
module arb_pick
    import npc_axi_pkg::*;
(
    input  logic       i_ifu_req,
    input  logic       i_lsu_rd_req,
    input  logic       i_lsu_wr_req,
    input  logic       i_last_ifu,
    output arb_state_e o_next
);

    logic       w_lsu_req;
    logic       w_lsu_wins;
    arb_state_e w_lsu_state;

    assign w_lsu_req   = i_lsu_rd_req | i_lsu_wr_req;
    assign w_lsu_state = i_lsu_rd_req ? RD_LSU : WR_LSU;

`ifdef ARB_RR_EN
    // Contention goes to whoever was not granted last.
    assign w_lsu_wins = i_last_ifu;
`else
    logic w_unused_last;
    assign w_unused_last = i_last_ifu;
    assign w_lsu_wins    = 1'b1;
`endif

    always_comb begin
        o_next = IDLE;
        if (i_ifu_req && w_lsu_req) begin
            o_next = w_lsu_wins ? w_lsu_state : RD_IFU;
        end else if (i_ifu_req) begin
            o_next = RD_IFU;
        end else if (w_lsu_req) begin
            o_next = w_lsu_state;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-lite arbiter.
// Build option: define ARB_RR_EN for round-robin, otherwise LSU has fixed priority.
module axi_lite_arbiter
    import npc_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    axi_lite_arbiter_if.slave  ifu,
    axi_lite_arbiter_if.slave  lsu,
    axi_lite_arbiter_if.master mem
);

    logic [1:0] r_state_raw;
    arb_state_e r_state;
    arb_state_e w_state_next;
    arb_state_e w_pick;
    logic       w_last_ifu;

    // IFU never writes; its write-side inputs are ignored.
    logic [ADDR_W+DATA_W+DATA_W/8+2:0] w_unused_ifu;
    assign w_unused_ifu = {ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bresp   = 2'b00;
    assign ifu.bvalid  = 1'b0;

    Reg #(
        .WIDTH     (2),
        .RESET_VAL (2'(IDLE))
    ) u_state_reg (
        .clk    (clk),
        .rst    (rst),
        .i_wen  (1'b1),
        .i_din  (w_state_next),
        .o_dout (r_state_raw)
    );

    assign r_state = arb_state_e'(r_state_raw);

    arb_pick u_pick (
        .i_ifu_req    (ifu.arvalid),
        .i_lsu_rd_req (lsu.arvalid),
        .i_lsu_wr_req (lsu.awvalid | lsu.wvalid),
        .i_last_ifu   (w_last_ifu),
        .o_next       (w_pick)
    );

`ifdef ARB_RR_EN
    logic r_last_ifu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_ifu <= 1'b1;
        end else if (r_state == IDLE && w_pick != IDLE) begin
            r_last_ifu <= (w_pick == RD_IFU);
        end
    end

    assign w_last_ifu = r_last_ifu;
`else
    assign w_last_ifu = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:           w_state_next = w_pick;
            RD_IFU, RD_LSU: if (mem.rvalid && mem.rready) w_state_next = IDLE;
            WR_LSU:         if (mem.bvalid && mem.bready) w_state_next = IDLE;
            default:        w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.araddr  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;
        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = 2'b00;
        ifu.rvalid  = 1'b0;
        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = 2'b00;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = 2'b00;
        lsu.bvalid  = 1'b0;
        case (r_state)
            RD_IFU: begin
                mem.araddr  = ifu.araddr;
                mem.arvalid = ifu.arvalid;
                mem.rready  = ifu.rready;
                ifu.arready = mem.arready;
                ifu.rdata   = mem.rdata;
                ifu.rresp   = mem.rresp;
                ifu.rvalid  = mem.rvalid;
            end
            RD_LSU: begin
                mem.araddr  = lsu.araddr;
                mem.arvalid = lsu.arvalid;
                mem.rready  = lsu.rready;
                lsu.arready = mem.arready;
                lsu.rdata   = mem.rdata;
                lsu.rresp   = mem.rresp;
                lsu.rvalid  = mem.rvalid;
            end
            WR_LSU: begin
                mem.awaddr  = lsu.awaddr;
                mem.awvalid = lsu.awvalid;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wvalid  = lsu.wvalid;
                mem.bready  = lsu.bready;
                lsu.awready = mem.awready;
                lsu.wready  = mem.wready;
                lsu.bresp   = mem.bresp;
                lsu.bvalid  = mem.bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Randomized bench for axi_lite_arbiter against a transaction-level ownership model.
module tb_axi_lite_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifu_bus ();
    axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lsu_bus ();
    axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    axi_lite_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .mem (mem_bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the slave (0 none, 1 IFU read, 2 LSU read, 3 LSU write).
    int owner    = 0;
    bit last_ifu = 1'b1;
    bit did_rst  = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit ifu_req, input bit lsu_rd, input bit lsu_wr);
        int lsu_tgt;
        lsu_tgt = lsu_rd ? 2 : 3;
        if (!ifu_req && !(lsu_rd || lsu_wr)) return 0;
        if (!(lsu_rd || lsu_wr)) return 1;
        if (!ifu_req) return lsu_tgt;
`ifdef ARB_RR_EN
        return last_ifu ? lsu_tgt : 1;
`else
        return lsu_tgt;
`endif
    endfunction

    task automatic drive_random();
        ifu_bus.araddr  = $urandom;
        ifu_bus.arvalid = ($urandom_range(1, 0) == 0);
        ifu_bus.rready  = ($urandom_range(2, 0) != 0);
        lsu_bus.araddr  = $urandom;
        lsu_bus.arvalid = ($urandom_range(2, 0) == 0);
        lsu_bus.rready  = ($urandom_range(2, 0) != 0);
        lsu_bus.awaddr  = $urandom;
        lsu_bus.awvalid = ($urandom_range(2, 0) == 0);
        lsu_bus.wdata   = $urandom;
        lsu_bus.wstrb   = 4'($urandom);
        lsu_bus.wvalid  = ($urandom_range(2, 0) == 0);
        lsu_bus.bready  = ($urandom_range(2, 0) != 0);
        mem_bus.arready = 1'($urandom);
        mem_bus.rdata   = $urandom;
        mem_bus.rresp   = 2'($urandom);
        mem_bus.rvalid  = ($urandom_range(3, 0) == 0);
        mem_bus.awready = 1'($urandom);
        mem_bus.wready  = 1'($urandom);
        mem_bus.bresp   = 2'($urandom);
        mem_bus.bvalid  = ($urandom_range(3, 0) == 0);
    endtask

    task automatic compare_all(input string tag);
        logic [35:0]  ifu_got, ifu_exp;
        logic [40:0]  lsu_got, lsu_exp;
        logic [104:0] mem_got, mem_exp;
        ifu_got = {ifu_bus.arready, ifu_bus.rdata, ifu_bus.rresp, ifu_bus.rvalid};
        lsu_got = {lsu_bus.arready, lsu_bus.rdata, lsu_bus.rresp, lsu_bus.rvalid,
                   lsu_bus.awready, lsu_bus.wready, lsu_bus.bresp, lsu_bus.bvalid};
        mem_got = {mem_bus.araddr, mem_bus.arvalid, mem_bus.rready, mem_bus.awaddr,
                   mem_bus.awvalid, mem_bus.wdata, mem_bus.wstrb, mem_bus.wvalid, mem_bus.bready};
        ifu_exp = '0;
        lsu_exp = '0;
        mem_exp = '0;
        case (owner)
            1: begin
                ifu_exp = {mem_bus.arready, mem_bus.rdata, mem_bus.rresp, mem_bus.rvalid};
                mem_exp = {ifu_bus.araddr, ifu_bus.arvalid, ifu_bus.rready, 71'd0};
            end
            2: begin
                lsu_exp = {mem_bus.arready, mem_bus.rdata, mem_bus.rresp, mem_bus.rvalid, 5'd0};
                mem_exp = {lsu_bus.araddr, lsu_bus.arvalid, lsu_bus.rready, 71'd0};
            end
            3: begin
                lsu_exp = {36'd0, mem_bus.awready, mem_bus.wready, mem_bus.bresp, mem_bus.bvalid};
                mem_exp = {34'd0, lsu_bus.awaddr, lsu_bus.awvalid, lsu_bus.wdata, lsu_bus.wstrb,
                           lsu_bus.wvalid, lsu_bus.bready};
            end
            default: ;
        endcase
        check({tag, "_ifu"}, 128'(ifu_got), 128'(ifu_exp));
        check({tag, "_lsu"}, 128'(lsu_got), 128'(lsu_exp));
        check({tag, "_mem"}, 128'(mem_got), 128'(mem_exp));
    endtask

    // Advance the model across the coming clock edge using the inputs now on the buses.
    task automatic step_model();
        case (owner)
            0: begin
                owner = pick(ifu_bus.arvalid, lsu_bus.arvalid, lsu_bus.awvalid | lsu_bus.wvalid);
                if (owner != 0) last_ifu = (owner == 1);
            end
            1: if (mem_bus.rvalid && ifu_bus.rready) owner = 0;
            2: if (mem_bus.rvalid && lsu_bus.rready) owner = 0;
            3: if (mem_bus.bvalid && lsu_bus.bready) owner = 0;
            default: owner = 0;
        endcase
    endtask

    initial begin
        ifu_bus.awaddr  = '0;
        ifu_bus.awvalid = 1'b0;
        ifu_bus.wdata   = '0;
        ifu_bus.wstrb   = '0;
        ifu_bus.wvalid  = 1'b0;
        ifu_bus.bready  = 1'b0;
        drive_random();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            #1;
            compare_all("run");
            if (!did_rst && owner == 3 && cyc > 300) begin
                rst = 1'b1;
                #1;
                owner    = 0;
                last_ifu = 1'b1;
                did_rst  = 1'b1;
                compare_all("midrst");
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive_random();
            end else begin
                step_model();
                @(posedge clk);
                #1;
                drive_random();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
